// File: rtl/sfp_ddm_poller.sv
// sfp_ddm_poller
//   Autonomous DDM poller for NPORT SFP cages. On each poll_tick it walks
//   the cages, selects each present one on the IIC mux and reads five
//   16-bit DDM words (A2h, addresses 96..104) into an internal register
//   file that the CPU reads through rd_port/rd_item. The CPU can borrow
//   the IIC bus through cpu_req/cpu_gnt; the bus changes hands only
//   between transactions.
//
//   Ports
//     clk, rst          core clock, synchronous active-high reset
//     poll_tick         sweep start pulse (ignored unless idle)
//     sfp_abs           1 = cage empty
//     iic_busy/fail/rdata  IIC master status; fail/rdata valid when busy falls
//     iic_cmd           2'b10 read pulse; iic_dev_id/iic_add/iic_two_bytes
//     iic_sel           one-hot cage select, 0 when idle or granted
//     cpu_req/cpu_gnt   bus hand-over: gnt rises only between transactions,
//                       stays high while req is high, drops the cycle after
//                       req falls
//     rd_port/rd_item   register-file read address; rd_data one clk later
//     port_valid        all five items of the cage read in its last visit
//     sweep_done        one-cycle pulse at end of sweep
//     poll_active       sweep in progress
//     dbg_state         current FSM state, for observation only

module sfp_ddm_poller #(
    parameter int NPORT     = 8,
    parameter int SETTLE    = 8,
    parameter int START_TMO = 16,
    parameter int DONE_TMO  = 200000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             poll_tick,
    input  logic [NPORT-1:0] sfp_abs,
    input  logic             iic_busy,
    input  logic             iic_fail,
    input  logic [15:0]      iic_rdata,
    output logic [1:0]       iic_cmd,
    output logic [6:0]       iic_dev_id,
    output logic [7:0]       iic_add,
    output logic             iic_two_bytes,
    output logic [NPORT-1:0] iic_sel,
    input  logic             cpu_req,
    output logic             cpu_gnt,
    input  logic [2:0]       rd_port,
    input  logic [2:0]       rd_item,
    output logic [15:0]      rd_data,
    output logic [NPORT-1:0] port_valid,
    output logic             sweep_done,
    output logic             poll_active,
    output logic [3:0]       dbg_state
);

    localparam int PW = (NPORT > 1) ? $clog2(NPORT) : 1;
    localparam logic [PW-1:0]    LAST_PORT  = PW'(NPORT - 1);
    localparam logic [NPORT-1:0] SEL_ONE    = {{(NPORT-1){1'b0}}, 1'b1};
    localparam logic [17:0]      SETTLE_LIM = 18'(SETTLE - 1);
    localparam logic [17:0]      START_LIM  = 18'(START_TMO);
    localparam logic [17:0]      DONE_LIM   = 18'(DONE_TMO);

    typedef enum logic [3:0] {
        S_IDLE, S_SEL, S_SETTLE, S_ISSUE, S_WAIT_BUSY,
        S_WAIT_DONE, S_STORE, S_NEXT, S_GRANT
    } state_t;

    state_t            state_q;
    logic [PW-1:0]     port_q;
    logic [2:0]        item_q;
    logic [17:0]       cnt_q;      // settle delay and both timeouts share it
    logic              from_next_q;
    logic              fail_q;
    logic [15:0]       rdata_q;
    logic [1:0]        cmd_q;
    logic [NPORT-1:0]  sel_q;
    logic [7:0]        add_q;
    logic              gnt_q;
    logic [NPORT-1:0]  valid_q;
    logic              done_q;
    logic              active_q;
    logic [15:0]       rd_data_q;
    logic [15:0]       rf_q [NPORT][5];

    // Items 0..4 sit on even addresses 96..104.
    function automatic logic [7:0] addr_of(input logic [2:0] it);
        return 8'd96 + {4'd0, it, 1'b0};
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            port_q      <= '0;
            item_q      <= '0;
            cnt_q       <= '0;
            from_next_q <= 1'b0;
            fail_q      <= 1'b0;
            rdata_q     <= '0;
            cmd_q       <= 2'b00;
            sel_q       <= '0;
            add_q       <= '0;
            gnt_q       <= 1'b0;
            valid_q     <= '0;
            done_q      <= 1'b0;
            active_q    <= 1'b0;
            rd_data_q   <= '0;
            for (int p = 0; p < NPORT; p++)
                for (int i = 0; i < 5; i++)
                    rf_q[p][i] <= '0;
        end else begin
            cmd_q  <= 2'b00;
            done_q <= 1'b0;

            // Read sees the pre-STORE value on a same-cycle collision.
            if (rd_item < 3'd5 && int'(rd_port) < NPORT)
                rd_data_q <= rf_q[rd_port[PW-1:0]][rd_item];
            else
                rd_data_q <= '0;

            case (state_q)
                S_IDLE: begin
                    if (cpu_req) begin
                        state_q     <= S_GRANT;
                        gnt_q       <= 1'b1;
                        from_next_q <= 1'b0;
                    end else if (poll_tick) begin
                        port_q   <= '0;
                        state_q  <= S_SEL;
                        active_q <= 1'b1;
                    end
                end
                S_SEL: begin
                    if (sfp_abs[port_q]) begin
                        valid_q[port_q] <= 1'b0;
                        state_q         <= S_NEXT;
                    end else begin
                        sel_q   <= SEL_ONE << port_q;
                        item_q  <= '0;
                        cnt_q   <= '0;
                        state_q <= S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    if (cnt_q >= SETTLE_LIM) begin
                        state_q <= S_ISSUE;
                        cmd_q   <= 2'b10;
                        add_q   <= addr_of(item_q);
                    end else begin
                        cnt_q <= cnt_q + 18'd1;
                    end
                end
                S_ISSUE: begin
                    state_q <= S_WAIT_BUSY;
                    cnt_q   <= '0;
                end
                S_WAIT_BUSY: begin
                    if (iic_busy) begin
                        state_q <= S_WAIT_DONE;
                        cnt_q   <= '0;
                    end else if (cnt_q == START_LIM) begin
                        fail_q  <= 1'b1;
                        state_q <= S_STORE;
                    end else if (cnt_q != '1) begin
                        cnt_q <= cnt_q + 18'd1;
                    end
                end
                S_WAIT_DONE: begin
                    // Busy falling is the only point where fail/rdata are valid.
                    if (!iic_busy) begin
                        fail_q  <= iic_fail;
                        rdata_q <= iic_rdata;
                        state_q <= S_STORE;
                    end else if (cnt_q == DONE_LIM) begin
                        fail_q  <= 1'b1;
                        state_q <= S_STORE;
                    end else if (cnt_q != '1) begin
                        cnt_q <= cnt_q + 18'd1;
                    end
                end
                S_STORE: begin
                    if (!fail_q) begin
                        rf_q[port_q][item_q] <= rdata_q;
                        if (item_q == 3'd4) begin
                            valid_q[port_q] <= 1'b1;
                            sel_q           <= '0;
                            state_q         <= S_NEXT;
                        end else begin
                            item_q  <= item_q + 3'd1;
                            cmd_q   <= 2'b10;
                            add_q   <= addr_of(item_q + 3'd1);
                            state_q <= S_ISSUE;
                        end
                    end else begin
                        valid_q[port_q] <= 1'b0;
                        sel_q           <= '0;
                        state_q         <= S_NEXT;
                    end
                end
                S_NEXT: begin
                    if (cpu_req) begin
                        state_q     <= S_GRANT;
                        gnt_q       <= 1'b1;
                        from_next_q <= 1'b1;
                        active_q    <= 1'b0;
                    end else if (port_q == LAST_PORT) begin
                        done_q   <= 1'b1;
                        active_q <= 1'b0;
                        state_q  <= S_IDLE;
                    end else begin
                        port_q  <= port_q + 1'b1;
                        state_q <= S_SEL;
                    end
                end
                S_GRANT: begin
                    if (!cpu_req) begin
                        gnt_q <= 1'b0;
                        if (!from_next_q) begin
                            state_q <= S_IDLE;
                        end else if (port_q == LAST_PORT) begin
                            // Grant taken after the last cage: the sweep ends here.
                            done_q  <= 1'b1;
                            state_q <= S_IDLE;
                        end else begin
                            port_q   <= port_q + 1'b1;
                            active_q <= 1'b1;
                            state_q  <= S_SEL;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign iic_cmd       = cmd_q;
    assign iic_dev_id    = 7'h51;
    assign iic_add       = add_q;
    assign iic_two_bytes = active_q;
    assign iic_sel       = sel_q;
    assign cpu_gnt       = gnt_q;
    assign rd_data       = rd_data_q;
    assign port_valid    = valid_q;
    assign sweep_done    = done_q;
    assign poll_active   = active_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_sfp_ddm_poller.sv
// Bench for sfp_ddm_poller: a scripted IIC slave answers commands from a
// per-cage/per-item response table, every command is logged, and a
// reference model derives the expected command sequence, register file
// and port_valid from the cage rules directly.
module tb_sfp_ddm_poller;

  localparam int DONE_TMO_TB = 300;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, poll_tick, iic_busy, iic_fail, cpu_req;
  logic [7:0]  sfp_abs;
  logic [15:0] iic_rdata;
  logic [2:0]  rd_port, rd_item;
  logic [1:0]  iic_cmd;
  logic [6:0]  iic_dev_id;
  logic [7:0]  iic_add, iic_sel, port_valid;
  logic        iic_two_bytes, cpu_gnt, sweep_done, poll_active;
  logic [15:0] rd_data;
  logic [3:0]  dbg_state;

  sfp_ddm_poller #(.NPORT(8), .SETTLE(8), .START_TMO(16), .DONE_TMO(DONE_TMO_TB)) dut (
    .clk(clk), .rst(rst), .poll_tick(poll_tick), .sfp_abs(sfp_abs),
    .iic_busy(iic_busy), .iic_fail(iic_fail), .iic_rdata(iic_rdata),
    .iic_cmd(iic_cmd), .iic_dev_id(iic_dev_id), .iic_add(iic_add),
    .iic_two_bytes(iic_two_bytes), .iic_sel(iic_sel),
    .cpu_req(cpu_req), .cpu_gnt(cpu_gnt), .rd_port(rd_port), .rd_item(rd_item),
    .rd_data(rd_data), .port_valid(port_valid), .sweep_done(sweep_done),
    .poll_active(poll_active), .dbg_state(dbg_state)
  );

  // Outputs bundled for reset-value checks.
  logic [52:0] out_vec;
  assign out_vec = {iic_cmd, iic_sel, iic_add, iic_two_bytes, iic_dev_id,
                    cpu_gnt, rd_data, port_valid, sweep_done, poll_active};
  localparam logic [52:0] RST_VEC = {2'b00, 8'h00, 8'h00, 1'b0, 7'h51,
                                     1'b0, 16'h0000, 8'h00, 1'b0, 1'b0};

  // ---------------- scoreboard state ----------------
  int total = 0;
  int bad   = 0;
  int          kind [8][5];  // 0 ok, 1 fail, 2 never busy, 3 busy stuck
  logic [15:0] rdat [8][5];
  logic [15:0] exp_rf [8][5];
  logic [7:0]  exp_valid;
  logic [7:0]  exp_q[$];     // expected commands, port*8+item
  int          log_q[$];     // observed commands
  int          slave_d = 0;  // fixed busy-rise delay, 0 = random
  int          sweep_cnt = 0;
  int          proto_err = 0;

  // ---------------- IIC slave model ----------------
  initial begin
    iic_busy = 1'b0; iic_fail = 1'b0; iic_rdata = 16'h0;
    forever begin
      @(negedge clk);
      if (iic_cmd === 2'b10) begin
        int p, it, k;
        p = -1;
        for (int i = 0; i < 8; i++) if (iic_sel[i]) p = i;
        it = (int'(iic_add) - 96) / 2;
        log_q.push_back(p * 8 + it);
        k = 2;
        if (p >= 0 && it >= 0 && it < 5 && iic_add[0] == 1'b0) k = kind[p][it];
        if (k != 2) begin
          repeat ((slave_d > 0) ? slave_d : $urandom_range(1, 3)) @(negedge clk);
          iic_busy = 1'b1;
          if (k == 3) begin
            // Master stays busy until the poller gives up and deselects.
            for (int n = 0; n < 5000 && iic_sel != 8'h00; n++) @(negedge clk);
            iic_busy = 1'b0; iic_fail = 1'b1; iic_rdata = ~rdat[p][it];
          end else begin
            repeat ($urandom_range(1, 5)) @(negedge clk);
            iic_busy  = 1'b0;
            iic_fail  = (k == 1);
            iic_rdata = (k == 1) ? ~rdat[p][it] : rdat[p][it];
          end
        end
      end
    end
  end

  // ---------------- bus-rule monitor ----------------
  always @(negedge clk) begin
    if (!rst) begin
      if (iic_cmd === 2'b10 && ($countones(iic_sel) != 1 || iic_two_bytes !== 1'b1)) proto_err++;
      if (iic_cmd !== 2'b00 && iic_cmd !== 2'b10) proto_err++;
      if (cpu_gnt === 1'b1 && (iic_sel !== 8'h00 || poll_active !== 1'b0)) proto_err++;
      if (iic_dev_id !== 7'h51) proto_err++;
      if (sweep_done === 1'b1) sweep_cnt++;
    end
  end

  // ---------------- reference model ----------------
  task automatic model_sweep(input logic [7:0] abs);
    bit ok;
    for (int p = 0; p < 8; p++) begin
      ok = 1'b0;
      if (!abs[p]) begin
        ok = 1'b1;
        for (int it = 0; it < 5 && ok; it++) begin
          exp_q.push_back(8'(p * 8 + it));
          if (kind[p][it] == 0) exp_rf[p][it] = rdat[p][it];
          else ok = 1'b0;
        end
      end
      exp_valid[p] = ok;
    end
  endtask

  task automatic model_reset();
    for (int p = 0; p < 8; p++) for (int it = 0; it < 5; it++) exp_rf[p][it] = 16'h0;
    exp_valid = 8'h00;
  endtask

  // ---------------- driver tasks ----------------
  task automatic cfg_all_ok();
    for (int p = 0; p < 8; p++)
      for (int it = 0; it < 5; it++) begin
        kind[p][it] = 0;
        rdat[p][it] = 16'($urandom);
      end
    slave_d = 0;
  endtask

  task automatic clear_logs();
    log_q.delete();
    exp_q.delete();
  endtask

  task automatic run_sweep(input int extra, output int cyc, output bit to);
    @(negedge clk);
    poll_tick = 1'b1;
    cyc = 0; to = 1'b1;
    while (cyc < 20000) begin
      @(negedge clk);
      cyc++;
      poll_tick = (cyc == extra);
      if (sweep_done === 1'b1) begin to = 1'b0; break; end
    end
    poll_tick = 1'b0;
  endtask

  task automatic read_rf(input int p, input int it, output logic [15:0] d);
    @(negedge clk);
    rd_port = 3'(p); rd_item = 3'(it);
    @(negedge clk);
    d = rd_data;
  endtask

  function automatic bit seq_match();
    if (log_q.size() != exp_q.size()) return 1'b0;
    for (int i = 0; i < log_q.size(); i++) if (log_q[i] != int'(exp_q[i])) return 1'b0;
    return 1'b1;
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [15:0] d;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if (out_vec !== RST_VEC) begin bad++; $display("FAIL reset_outputs: got %h required %h", out_vec, RST_VEC); end
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (out_vec !== RST_VEC) begin bad++; $display("FAIL reset_idle_outputs: got %h required %h", out_vec, RST_VEC); end
    model_reset();
    for (int p = 0; p < 8; p++) begin
      read_rf(p, p % 5, d);
      total++;
      if (d !== 16'h0) begin bad++; $display("FAIL reset_rf[%0d]: got %h required 0000", p, d); end
    end
  endtask

  task automatic test_all_absent();
    int cyc; bit to; int sc;
    clear_logs(); cfg_all_ok();
    sfp_abs = 8'hFF;
    model_sweep(sfp_abs);
    sc = sweep_cnt;
    run_sweep(0, cyc, to);
    total++;
    if (to !== 1'b0 || cyc !== 17) begin bad++; $display("FAIL absent_len: got %0d cycles (timeout=%0d) required 17", cyc, to); end
    total++;
    if (log_q.size() !== 0) begin bad++; $display("FAIL absent_cmds: got %0d commands required 0", log_q.size()); end
    total++;
    if (port_valid !== 8'h00) begin bad++; $display("FAIL absent_valid: got %h required 00", port_valid); end
    @(negedge clk);
    total++;
    if (sweep_cnt !== sc + 1) begin bad++; $display("FAIL absent_done_pulse: got %0d pulses required 1", sweep_cnt - sc); end
  endtask

  task automatic test_cage3();
    int cyc; bit to; logic [15:0] d, e;
    clear_logs(); cfg_all_ok();
    for (int it = 0; it < 5; it++) rdat[3][it] = 16'h1A2B + 16'(it);
    sfp_abs = 8'hF7;
    model_sweep(sfp_abs);
    run_sweep(0, cyc, to);
    total++;
    if (to !== 1'b0) begin bad++; $display("FAIL cage3_timeout: no sweep_done in %0d cycles", cyc); end
    total++;
    if (seq_match() !== 1'b1) begin bad++; $display("FAIL cage3_cmd_seq: got %0d cmds required %0d", log_q.size(), exp_q.size()); end
    total++;
    if (port_valid !== 8'h08) begin bad++; $display("FAIL cage3_valid: got %h required 08", port_valid); end
    read_rf(3, 2, d);
    total++;
    if (d !== 16'h1A2D) begin bad++; $display("FAIL cage3_rd_item2: got %h required 1a2d", d); end
    for (int it = 0; it < 8; it++) begin
      read_rf(3, it, d);
      e = 16'h0;
      if (it < 5) e = exp_rf[3][it];
      total++;
      if (d !== e) begin bad++; $display("FAIL cage3_rf[%0d]: got %h required %h", it, d, e); end
    end
  endtask

  task automatic test_cage5_fail();
    int cyc; bit to; logic [15:0] d;
    clear_logs(); cfg_all_ok();
    sfp_abs = 8'hDF;
    model_sweep(sfp_abs);
    run_sweep(0, cyc, to);
    clear_logs(); cfg_all_ok();
    kind[5][2] = 1;
    model_sweep(sfp_abs);
    run_sweep(0, cyc, to);
    total++;
    if (to !== 1'b0) begin bad++; $display("FAIL cage5_timeout: no sweep_done in %0d cycles", cyc); end
    total++;
    if (seq_match() !== 1'b1 || log_q.size() !== 3) begin bad++; $display("FAIL cage5_cmd_seq: got %0d cmds required 3", log_q.size()); end
    total++;
    if (port_valid[5] !== 1'b0 || port_valid !== exp_valid) begin bad++; $display("FAIL cage5_valid: got %h required %h", port_valid, exp_valid); end
    for (int it = 0; it < 5; it++) begin
      read_rf(5, it, d);
      total++;
      if (d !== exp_rf[5][it]) begin bad++; $display("FAIL cage5_rf[%0d]: got %h required %h", it, d, exp_rf[5][it]); end
    end
  endtask

  task automatic test_timeouts();
    int cyc; bit to; logic [15:0] d;
    // Cage 1 only, busy never rises: 7 absent cages x 2 cycles, plus
    // SEL 1 + settle 8 + ISSUE 1 + WAIT_BUSY 17 (count 0..16) + STORE 1
    // + NEXT 1 for cage 1, plus one cycle to the sweep_done pulse.
    clear_logs(); cfg_all_ok();
    kind[1][0] = 2;
    sfp_abs = 8'hFD;
    model_sweep(sfp_abs);
    run_sweep(0, cyc, to);
    total++;
    if (to !== 1'b0 || cyc !== 44) begin bad++; $display("FAIL start_tmo_len: got %0d cycles required 44", cyc); end
    total++;
    if (port_valid !== exp_valid) begin bad++; $display("FAIL start_tmo_valid: got %h required %h", port_valid, exp_valid); end
    // Cage 4 only, busy stuck high from the first cycle of WAIT_BUSY:
    // WAIT_BUSY 1 + WAIT_DONE 301 (count 0..300) replace the 17 above.
    clear_logs(); cfg_all_ok();
    kind[4][0] = 3; slave_d = 1;
    sfp_abs = 8'hEF;
    model_sweep(sfp_abs);
    run_sweep(0, cyc, to);
    total++;
    if (to !== 1'b0 || cyc !== 329) begin bad++; $display("FAIL done_tmo_len: got %0d cycles required 329", cyc); end
    // Mixed sweep: both timeouts among working cages, sweep must continue.
    clear_logs(); cfg_all_ok();
    kind[1][0] = 2; kind[4][3] = 3;
    sfp_abs = 8'(($urandom & 32'hED));
    model_sweep(sfp_abs);
    run_sweep(0, cyc, to);
    total++;
    if (to !== 1'b0 || seq_match() !== 1'b1) begin bad++; $display("FAIL tmo_mix_seq: got %0d cmds required %0d", log_q.size(), exp_q.size()); end
    total++;
    if (port_valid !== exp_valid) begin bad++; $display("FAIL tmo_mix_valid: got %h required %h", port_valid, exp_valid); end
    for (int p = 0; p < 8; p++)
      for (int it = 0; it < 5; it++) begin
        read_rf(p, it, d);
        total++;
        if (d !== exp_rf[p][it]) begin bad++; $display("FAIL tmo_mix_rf[%0d][%0d]: got %h required %h", p, it, d, exp_rf[p][it]); end
      end
  endtask

  task automatic test_grant_idle();
    int sc;
    @(negedge clk);
    cpu_req = 1'b1;
    @(negedge clk);
    total++;
    if (cpu_gnt !== 1'b1 || poll_active !== 1'b0) begin bad++; $display("FAIL idle_gnt: got gnt=%0b active=%0b required 1/0", cpu_gnt, poll_active); end
    sc = sweep_cnt;
    poll_tick = 1'b1;
    @(negedge clk);
    poll_tick = 1'b0;
    repeat (25) @(negedge clk);
    total++;
    if (poll_active !== 1'b0 || sweep_cnt !== sc) begin bad++; $display("FAIL idle_gnt_tick: got active=%0b sweeps=%0d required 0/0", poll_active, sweep_cnt - sc); end
    cpu_req = 1'b0;
    @(negedge clk);
    total++;
    if (cpu_gnt !== 1'b0) begin bad++; $display("FAIL idle_gnt_release: got %0b required 0", cpu_gnt); end
  endtask

  task automatic test_cpu_grant();
    int n, c2, c3, sz, sc; bit found; logic [15:0] d;
    clear_logs(); cfg_all_ok();
    sfp_abs = 8'hF3;
    model_sweep(sfp_abs);
    sc = sweep_cnt;
    @(negedge clk); poll_tick = 1'b1;
    @(negedge clk); poll_tick = 1'b0;
    found = 1'b0;
    for (n = 0; n < 3000 && !found; n++) begin
      @(negedge clk);
      foreach (log_q[i]) if (log_q[i] == 2 * 8 + 2) found = 1'b1;
    end
    cpu_req = 1'b1;
    for (n = 0; n < 3000 && cpu_gnt !== 1'b1; n++) @(negedge clk);
    total++;
    if (found !== 1'b1 || cpu_gnt !== 1'b1) begin bad++; $display("FAIL grant_rise: got item2_seen=%0b gnt=%0b required 1/1", found, cpu_gnt); end
    c2 = 0; c3 = 0;
    foreach (log_q[i]) begin
      if (log_q[i] / 8 == 2) c2++;
      if (log_q[i] / 8 == 3) c3++;
    end
    total++;
    if (c2 !== 5 || c3 !== 0 || iic_sel !== 8'h00) begin bad++; $display("FAIL grant_boundary: got cage2=%0d cage3=%0d sel=%h required 5/0/00", c2, c3, iic_sel); end
    sz = log_q.size();
    poll_tick = 1'b1;
    @(negedge clk);
    poll_tick = 1'b0;
    repeat (20) @(negedge clk);
    total++;
    if (log_q.size() !== sz || cpu_gnt !== 1'b1 || poll_active !== 1'b0) begin bad++; $display("FAIL grant_hold: got cmds=%0d gnt=%0b active=%0b required %0d/1/0", log_q.size(), cpu_gnt, poll_active, sz); end
    cpu_req = 1'b0;
    for (n = 0; n < 3000 && sweep_done !== 1'b1; n++) @(negedge clk);
    total++;
    if (sweep_done !== 1'b1 || seq_match() !== 1'b1) begin bad++; $display("FAIL grant_resume_seq: got %0d cmds required %0d", log_q.size(), exp_q.size()); end
    repeat (30) @(negedge clk);
    total++;
    if (sweep_cnt !== sc + 1 || poll_active !== 1'b0 || cpu_gnt !== 1'b0) begin bad++; $display("FAIL grant_end: got sweeps=%0d active=%0b gnt=%0b required 1/0/0", sweep_cnt - sc, poll_active, cpu_gnt); end
    total++;
    if (port_valid !== exp_valid) begin bad++; $display("FAIL grant_valid: got %h required %h", port_valid, exp_valid); end
    for (int p = 2; p < 4; p++)
      for (int it = 0; it < 5; it++) begin
        read_rf(p, it, d);
        total++;
        if (d !== exp_rf[p][it]) begin bad++; $display("FAIL grant_rf[%0d][%0d]: got %h required %h", p, it, d, exp_rf[p][it]); end
      end
  endtask

  task automatic test_random();
    int cyc, sc; bit to; logic [15:0] d;
    for (int r = 0; r < 3; r++) begin
      clear_logs(); cfg_all_ok();
      sfp_abs = 8'($urandom);
      for (int p = 0; p < 8; p++)
        if ($urandom_range(0, 3) == 0) kind[p][$urandom_range(0, 4)] = $urandom_range(1, 3);
      model_sweep(sfp_abs);
      sc = sweep_cnt;
      // A second tick mid-sweep must be dropped.
      run_sweep(5, cyc, to);
      repeat (30) @(negedge clk);
      total++;
      if (to !== 1'b0 || sweep_cnt !== sc + 1 || poll_active !== 1'b0) begin bad++; $display("FAIL rand%0d_sweeps: got %0d sweeps (timeout=%0d) required 1", r, sweep_cnt - sc, to); end
      total++;
      if (seq_match() !== 1'b1) begin bad++; $display("FAIL rand%0d_cmd_seq: got %0d cmds required %0d", r, log_q.size(), exp_q.size()); end
      total++;
      if (port_valid !== exp_valid) begin bad++; $display("FAIL rand%0d_valid: got %h required %h", r, port_valid, exp_valid); end
      for (int p = 0; p < 8; p++)
        for (int it = 0; it < 5; it++) begin
          read_rf(p, it, d);
          total++;
          if (d !== exp_rf[p][it]) begin bad++; $display("FAIL rand%0d_rf[%0d][%0d]: got %h required %h", r, p, it, d, exp_rf[p][it]); end
        end
    end
  endtask

  task automatic test_reset_mid();
    int n, cyc; bit to; logic [15:0] d;
    clear_logs(); cfg_all_ok();
    kind[0][2] = 3;
    sfp_abs = 8'hFE;
    @(negedge clk); poll_tick = 1'b1;
    @(negedge clk); poll_tick = 1'b0;
    for (n = 0; n < 3000 && !(log_q.size() >= 3 && iic_busy === 1'b1); n++) @(negedge clk);
    repeat (5) @(negedge clk);
    total++;
    if (iic_busy !== 1'b1 || iic_sel !== 8'h01) begin bad++; $display("FAIL rstmid_setup: got busy=%0b sel=%h required 1/01", iic_busy, iic_sel); end
    rst = 1'b1;
    @(negedge clk);
    total++;
    if (out_vec !== RST_VEC) begin bad++; $display("FAIL rstmid_outputs: got %h required %h", out_vec, RST_VEC); end
    rst = 1'b0;
    model_reset();
    for (n = 0; n < 100 && iic_busy !== 1'b0; n++) @(negedge clk);
    for (int it = 0; it < 2; it++) begin
      read_rf(0, it, d);
      total++;
      if (d !== 16'h0) begin bad++; $display("FAIL rstmid_rf[%0d]: got %h required 0000", it, d); end
    end
    clear_logs(); cfg_all_ok();
    sfp_abs = 8'($urandom | 32'h1) & 8'hFE;
    model_sweep(sfp_abs);
    run_sweep(0, cyc, to);
    total++;
    if (to !== 1'b0 || log_q.size() == 0 || log_q[0] !== 0) begin bad++; $display("FAIL rstmid_first_cmd: got %0d required 0 (cage 0 item 0)", (log_q.size() > 0) ? log_q[0] : -1); end
    total++;
    if (seq_match() !== 1'b1 || port_valid !== exp_valid) begin bad++; $display("FAIL rstmid_sweep: got valid=%h cmds=%0d required %h/%0d", port_valid, log_q.size(), exp_valid, exp_q.size()); end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst = 1'b1; poll_tick = 1'b0; cpu_req = 1'b0; sfp_abs = 8'hFF;
    rd_port = 3'd0; rd_item = 3'd0;
    cfg_all_ok();
    test_reset();
    test_all_absent();
    test_cage3();
    test_cage5_fail();
    test_timeouts();
    test_grant_idle();
    test_cpu_grant();
    test_random();
    test_reset_mid();
    total++;
    if (proto_err !== 0) begin bad++; $display("FAIL bus_rules: got %0d violations required 0", proto_err); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
